// File: rtl/hamming_serial_tx.sv
// Hamming (7,4)/(8,4) encoder with codeword FIFO and valid/ready serializer.
// Ports: clk, reset (sync, active-high); in_bit/in_valid/in_ready message input;
//        out_bit/out_valid/out_ready/out_sof codeword output; fifo_count, cw_sent status.
module hamming_serial_tx #(
    parameter int EXTENDED = 0,
    parameter int DEPTH    = 4,
    localparam int N  = 7 + EXTENDED,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic [CW-1:0] fifo_count,
    output logic [15:0]   cw_sent
);

    localparam int AW = $clog2(DEPTH);

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    // message collection: msg holds m3,m2,m1 while m0 is still on in_bit
    logic [1:0] idx;
    logic [2:0] msg;
    logic       in_fire;
    logic       push;

    logic       m3, m2, m1, m0;
    logic       p0, p1, p2;
    logic [6:0] c7;
    logic [N-1:0] cw_new;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    logic          state;
    logic [N-1:0]  sreg;
    logic [2:0]    bcnt;
    logic          last;
    logic          accept;

    assign in_ready = (fifo_count < CW'(DEPTH));
    assign in_fire  = in_valid && in_ready;
    assign push     = in_fire && (idx == 2'd3);

    assign m3 = msg[2];
    assign m2 = msg[1];
    assign m1 = msg[0];
    assign m0 = in_bit;
    assign p0 = m3 ^ m2 ^ m0;
    assign p1 = m2 ^ m1 ^ m0;
    assign p2 = m3 ^ m2 ^ m1;
    assign c7 = {p2, p0, p1, m3, m2, m1, m0};

    generate
        if (EXTENDED != 0) begin : g_ext
            assign cw_new = {^c7, c7};
        end else begin : g_std
            assign cw_new = c7;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= 2'd0;
            msg <= 3'd0;
        end else if (in_fire) begin
            idx <= idx + 2'd1;
            msg <= {msg[1:0], in_bit};
        end
    end

    // serializer handshake; a pop reloads the shift register on the same
    // edge the last bit leaves, so back-to-back codewords have no bubble
    assign accept = (state == SHIFT) && out_ready;
    assign last   = (bcnt == 3'(N - 1));
    assign pop    = (fifo_count != '0) &&
                    ((state == IDLE) || (accept && last));

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= cw_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bcnt    <= 3'd0;
            cw_sent <= 16'd0;
        end else begin
            if (pop) begin
                state <= SHIFT;
                sreg  <= mem[rd_ptr];
                bcnt  <= 3'd0;
            end else if (accept) begin
                sreg <= {sreg[N-2:0], 1'b0};
                if (last) begin
                    state <= IDLE;
                    bcnt  <= 3'd0;
                end else begin
                    bcnt <= bcnt + 3'd1;
                end
            end
            if (accept && last) begin
                cw_sent <= cw_sent + 16'd1;
            end
        end
    end

    assign out_valid = (state == SHIFT);
    assign out_bit   = out_valid && sreg[N-1];
    assign out_sof   = out_valid && (bcnt == 3'd0);

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx: one (7,4) instance and one (8,4)
// instance, both DEPTH=4, driven from per-scenario tasks.
module tb_hamming_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_bit0, in_valid0, in_ready0, out_bit0, out_valid0, out_ready0, out_sof0;
    logic [2:0] fifo_count0;
    logic [15:0] cw_sent0;
    logic       in_bit1, in_valid1, in_ready1, out_bit1, out_valid1, out_ready1, out_sof1;
    logic [2:0] fifo_count1;
    logic [15:0] cw_sent1;

    int n_cmp = 0;
    int n_err = 0;

    logic rx0[$];
    logic sf0[$];
    logic rx1[$];

    always #5 clk = ~clk;

    hamming_serial_tx #(.EXTENDED(0), .DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .in_bit(in_bit0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_bit(out_bit0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_sof(out_sof0), .fifo_count(fifo_count0),
        .cw_sent(cw_sent0)
    );

    hamming_serial_tx #(.EXTENDED(1), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .in_bit(in_bit1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_bit(out_bit1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sof(out_sof1), .fifo_count(fifo_count1),
        .cw_sent(cw_sent1)
    );

    // record bits that the next rising edge will accept
    always @(negedge clk) begin
        if (!reset && out_valid0 && out_ready0) begin
            rx0.push_back(out_bit0);
            sf0.push_back(out_sof0);
        end
        if (!reset && out_valid1 && out_ready1) begin
            rx1.push_back(out_bit1);
        end
    end

    function automatic logic [63:0] rx0v();
        logic [63:0] v = '0;
        foreach (rx0[i]) v = {v[62:0], rx0[i]};
        return v;
    endfunction

    function automatic logic [63:0] sf0v();
        logic [63:0] v = '0;
        foreach (sf0[i]) v = {v[62:0], sf0[i]};
        return v;
    endfunction

    function automatic logic [63:0] rx1v();
        logic [63:0] v = '0;
        foreach (rx1[i]) v = {v[62:0], rx1[i]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        tick();
        reset = 1'b0;
        rx0.delete();
        sf0.delete();
        rx1.delete();
    endtask

    // feed nbits of bits (MSB first) into dut0; mode 0/1 = out_ready level, 2 = random
    task automatic run0(input logic [63:0] bits, input int nbits, input int ncyc,
                        input int mode, output int fed);
        int k = 0;
        logic acc;
        for (int c = 0; c < ncyc; c++) begin
            if (mode == 2) out_ready0 = 1'($urandom_range(0, 1));
            else out_ready0 = (mode == 1);
            in_valid0 = (k < nbits);
            in_bit0 = (k < nbits) ? bits[nbits-1-k] : 1'b0;
            acc = in_valid0 && in_ready0;
            tick();
            if (acc) k++;
        end
        in_valid0 = 1'b0;
        fed = k;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid0 = 1'b1;
        in_bit0 = 1'b1;
        out_ready0 = 1'b1;
        tick();
        n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid0); end
        n_cmp++; if (out_sof0 !== 1'b0) begin n_err++; $display("FAIL reset_out_sof: got %0b want 0", out_sof0); end
        n_cmp++; if (out_bit0 !== 1'b0) begin n_err++; $display("FAIL reset_out_bit: got %0b want 0", out_bit0); end
        n_cmp++; if (fifo_count0 !== 3'd0) begin n_err++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count0); end
        n_cmp++; if (cw_sent0 !== 16'd0) begin n_err++; $display("FAIL reset_cw_sent: got %0d want 0", cw_sent0); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready0); end
        do_reset();
    endtask

    task automatic test_basic();
        int fed;
        do_reset();
        run0(64'b1011, 4, 4, 1, fed);
        n_cmp++; if (fifo_count0 !== 3'd1) begin n_err++; $display("FAIL basic_push_count: got %0d want 1", fifo_count0); end
        n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got %0b want 0", out_valid0); end
        tick();
        n_cmp++; if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL basic_latency_valid: got %0b want 1", out_valid0); end
        n_cmp++; if (out_sof0 !== 1'b1) begin n_err++; $display("FAIL basic_latency_sof: got %0b want 1", out_sof0); end
        run0(64'b0, 0, 10, 1, fed);
        n_cmp++; if (rx0.size() !== 7) begin n_err++; $display("FAIL basic_len: got %0d want 7", rx0.size()); end
        n_cmp++; if (rx0v() !== 64'b0001011) begin n_err++; $display("FAIL basic_stream: got %0h want %0h", rx0v(), 64'b0001011); end
        n_cmp++; if (sf0v() !== 64'b1000000) begin n_err++; $display("FAIL basic_sof: got %0h want %0h", sf0v(), 64'b1000000); end
        n_cmp++; if (cw_sent0 !== 16'd1) begin n_err++; $display("FAIL basic_cw_sent: got %0d want 1", cw_sent0); end
        n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %0b want 0", out_valid0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b0001_1111;
        int k = 0;
        int gaps = 0;
        bit started = 0;
        logic acc;
        do_reset();
        out_ready1 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_valid1 = (k < 8);
            in_bit1 = (k < 8) ? bits[7-k] : 1'b0;
            acc = in_valid1 && in_ready1;
            if (out_valid1) started = 1;
            else if (started && rx1.size() < 16) gaps++;
            tick();
            if (acc) k++;
        end
        in_valid1 = 1'b0;
        n_cmp++; if (k !== 8) begin n_err++; $display("FAIL b2b_fed: got %0d want 8", k); end
        n_cmp++; if (rx1.size() !== 16) begin n_err++; $display("FAIL b2b_len: got %0d want 16", rx1.size()); end
        n_cmp++; if (rx1v() !== 64'hB1FF) begin n_err++; $display("FAIL b2b_stream: got %0h want b1ff", rx1v()); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL b2b_bubble: got %0d want 0", gaps); end
        n_cmp++; if (cw_sent1 !== 16'd2) begin n_err++; $display("FAIL b2b_cw_sent: got %0d want 2", cw_sent1); end
    endtask

    task automatic test_backpressure();
        int fed;
        logic [63:0] exp = {7'b0110001, 7'b1010010, 7'b1110100,
                            7'b1101000, 7'b1000101, 7'b0100110};
        do_reset();
        run0(64'h124856, 24, 40, 0, fed);
        n_cmp++; if (fed !== 20) begin n_err++; $display("FAIL bp_accepted: got %0d want 20", fed); end
        n_cmp++; if (fifo_count0 !== 3'd4) begin n_err++; $display("FAIL bp_count: got %0d want 4", fifo_count0); end
        n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b want 0", in_ready0); end
        n_cmp++; if (out_sof0 !== 1'b1) begin n_err++; $display("FAIL bp_held_sof: got %0b want 1", out_sof0); end
        n_cmp++; if (cw_sent0 !== 16'd0) begin n_err++; $display("FAIL bp_cw_sent_stall: got %0d want 0", cw_sent0); end
        run0(64'h6, 4, 80, 1, fed);
        n_cmp++; if (fed !== 4) begin n_err++; $display("FAIL bp_rest: got %0d want 4", fed); end
        n_cmp++; if (rx0.size() !== 42) begin n_err++; $display("FAIL bp_len: got %0d want 42", rx0.size()); end
        n_cmp++; if (rx0v() !== exp) begin n_err++; $display("FAIL bp_stream: got %0h want %0h", rx0v(), exp); end
        n_cmp++; if (cw_sent0 !== 16'd6) begin n_err++; $display("FAIL bp_cw_sent: got %0d want 6", cw_sent0); end
    endtask

    task automatic test_random_stall();
        logic [23:0] bits = 24'h9C3AF0;
        logic [63:0] exp = {7'b1011001, 7'b0011100, 7'b1100011,
                            7'b0111010, 7'b1111111, 7'b0000000};
        logic [63:0] sexp = {6{7'b1000000}};
        int k = 0;
        logic acc, pv, pr, pb;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (rx0.size() >= 42) break;
            out_ready0 = 1'($urandom_range(0, 1));
            in_valid0 = (k < 24) && ($urandom_range(0, 2) != 0);
            in_bit0 = (k < 24) ? bits[23-k] : 1'b0;
            acc = in_valid0 && in_ready0;
            pv = out_valid0;
            pr = out_ready0;
            pb = out_bit0;
            tick();
            if (acc) k++;
            if (pv && !pr) begin
                n_cmp++; if (out_valid0 !== 1'b1 || out_bit0 !== pb) begin n_err++; $display("FAIL stall_hold: got v=%0b b=%0b want v=1 b=%0b", out_valid0, out_bit0, pb); end
            end
        end
        in_valid0 = 1'b0;
        n_cmp++; if (rx0.size() !== 42) begin n_err++; $display("FAIL rand_len: got %0d want 42", rx0.size()); end
        n_cmp++; if (rx0v() !== exp) begin n_err++; $display("FAIL rand_stream: got %0h want %0h", rx0v(), exp); end
        n_cmp++; if (sf0v() !== sexp) begin n_err++; $display("FAIL rand_sof: got %0h want %0h", sf0v(), sexp); end
    endtask

    task automatic test_reset_mid();
        int fed;
        do_reset();
        run0(64'b111110, 6, 8, 1, fed);
        reset = 1'b1;
        in_valid0 = 1'b1;
        in_bit0 = 1'b1;
        tick();
        n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %0b want 0", out_valid0); end
        n_cmp++; if (out_sof0 !== 1'b0) begin n_err++; $display("FAIL mid_out_sof: got %0b want 0", out_sof0); end
        n_cmp++; if (out_bit0 !== 1'b0) begin n_err++; $display("FAIL mid_out_bit: got %0b want 0", out_bit0); end
        n_cmp++; if (fifo_count0 !== 3'd0) begin n_err++; $display("FAIL mid_fifo_count: got %0d want 0", fifo_count0); end
        n_cmp++; if (cw_sent0 !== 16'd0) begin n_err++; $display("FAIL mid_cw_sent: got %0d want 0", cw_sent0); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %0b want 1", in_ready0); end
        reset = 1'b0;
        in_valid0 = 1'b0;
        rx0.delete();
        sf0.delete();
        run0(64'h5, 4, 20, 1, fed);
        n_cmp++; if (rx0.size() !== 7) begin n_err++; $display("FAIL mid_len: got %0d want 7", rx0.size()); end
        n_cmp++; if (rx0v() !== 64'b1000101) begin n_err++; $display("FAIL mid_stream: got %0h want %0h", rx0v(), 64'b1000101); end
        n_cmp++; if (cw_sent0 !== 16'd1) begin n_err++; $display("FAIL mid_cw_sent_after: got %0d want 1", cw_sent0); end
    endtask

    initial begin
        reset = 1'b1;
        in_bit0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        in_bit1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
